// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 bank arbiter slice.
package l2_arb_pkg;

   typedef enum logic [1:0] {
      StInitZero = 2'd0,
      StRun      = 2'd1,
      StDrain    = 2'd2
   } arb_state_e;

   localparam int unsigned TCDM_DW  = 36;
   localparam int unsigned TAG_W    = 4;
   localparam int unsigned RSP_ID_W = 4;

   // Response id reserved for zeroing writes; never matches a master index (max 8 masters).
   localparam logic [RSP_ID_W-1:0] INIT_RSP_ID = 4'hF;

   function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                  input logic [31:0] word);
      return base + {word[29:0], 2'b00};
   endfunction

endpackage

// File: rtl/l2_bank_arbiter_if.sv
// TCDM bus bundle: per-master request/response ports plus the shared bank port.
interface l2_bank_arbiter_if #(
   parameter int unsigned NB_MASTERS = 2
);
   import l2_arb_pkg::*;

   logic [NB_MASTERS-1:0]              m_req;
   logic [NB_MASTERS-1:0][31:0]        m_add;
   logic [NB_MASTERS-1:0]              m_wen;
   logic [NB_MASTERS-1:0][3:0]         m_be;
   logic [NB_MASTERS-1:0][TCDM_DW-1:0] m_wdata;
   logic [NB_MASTERS-1:0]              m_gnt;
   logic [NB_MASTERS-1:0]              m_r_valid;
   logic [NB_MASTERS-1:0][TCDM_DW-1:0] m_r_rdata;
   logic [NB_MASTERS-1:0]              m_r_opc;

   logic                               mem_req;
   logic [31:0]                        mem_add;
   logic                               mem_wen;
   logic [3:0]                         mem_be;
   logic [TCDM_DW-1:0]                 mem_wdata;
   logic                               mem_gnt;
   logic                               mem_r_valid;
   logic [TCDM_DW-1:0]                 mem_r_rdata;

   // Arbiter view.
   modport slave (
      input  m_req, m_add, m_wen, m_be, m_wdata,
      output m_gnt, m_r_valid, m_r_rdata, m_r_opc,
      output mem_req, mem_add, mem_wen, mem_be, mem_wdata,
      input  mem_gnt, mem_r_valid, mem_r_rdata
   );

   // Environment view: requesters and the bank.
   modport master (
      output m_req, m_add, m_wen, m_be, m_wdata,
      input  m_gnt, m_r_valid, m_r_rdata, m_r_opc,
      input  mem_req, mem_add, mem_wen, mem_be, mem_wdata,
      output mem_gnt, mem_r_valid, mem_r_rdata
   );

endinterface

// File: rtl/rr_arb_tree_lite.sv
// Round-robin priority picker: first requester at or after ptr_i, searching upward with wrap.
module rr_arb_tree_lite #(
   parameter int unsigned NumIn = 2,
   localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1
) (
   input  logic [NumIn-1:0] req_i,
   input  logic [IdxW-1:0]  ptr_i,
   output logic [NumIn-1:0] gnt_o,
   output logic [IdxW-1:0]  idx_o,
   output logic             valid_o
);

   int unsigned      cand;
   logic [IdxW-1:0]  cand_idx;

   always_comb begin
      idx_o    = '0;
      valid_o  = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned off = 0; off < NumIn; off++) begin
         cand     = (32'(ptr_i) + off) % NumIn;
         cand_idx = IdxW'(cand);
         if (!valid_o && req_i[cand_idx]) begin
            valid_o = 1'b1;
            idx_o   = cand_idx;
         end
      end
      gnt_o = valid_o ? (NumIn'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/l2_bank_arbiter.sv
// Round-robin share of one single-port L2 bank among NB_MASTERS, with a zeroing sequencer
// that clears the bank after reset and on clear_i.
module l2_bank_arbiter
   import l2_arb_pkg::*;
#(
   parameter int unsigned NB_MASTERS = 2,
   parameter int unsigned BANK_WORDS = 8192,
   parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   output logic                busy_o,
   l2_bank_arbiter_if.slave    bus
);

   localparam int unsigned   IdxW   = $clog2(NB_MASTERS);
   localparam int unsigned   CntW   = $clog2(BANK_WORDS);
   localparam logic [CntW-1:0] CntMax = CntW'(BANK_WORDS - 1);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NB_MASTERS - 1);

   arb_state_e             state_q;
   logic [IdxW-1:0]        rr_ptr_q;
   logic [CntW-1:0]        cnt_q;
   logic                   rsp_pend_q;
   logic [RSP_ID_W-1:0]    rsp_id_q;
   logic                   busy_q;

   logic [NB_MASTERS-1:0]  win_oh;
   logic [IdxW-1:0]        win_idx;
   logic                   win_valid;
   logic                   handshake;
   logic [IdxW-1:0]        next_ptr;

   rr_arb_tree_lite #(
      .NumIn (NB_MASTERS)
   ) u_rr_arb (
      .req_i   (bus.m_req),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (win_oh),
      .idx_o   (win_idx),
      .valid_o (win_valid)
   );

   always_comb begin
      bus.mem_req   = 1'b0;
      bus.mem_add   = BASE_ADDR;
      bus.mem_wen   = 1'b1;
      bus.mem_be    = 4'h0;
      bus.mem_wdata = '0;
      bus.m_gnt     = '0;
      case (state_q)
         StInitZero: begin
            bus.mem_req   = 1'b1;
            bus.mem_add   = word_byte_addr(BASE_ADDR, 32'(cnt_q));
            bus.mem_wen   = 1'b0;
            bus.mem_be    = 4'hF;
            bus.mem_wdata = '0;
         end
         StRun: begin
            bus.mem_req   = win_valid;
            bus.mem_add   = bus.m_add[win_idx];
            bus.mem_wen   = bus.m_wen[win_idx];
            bus.mem_be    = bus.m_be[win_idx];
            bus.mem_wdata = bus.m_wdata[win_idx];
            bus.m_gnt     = win_oh & {NB_MASTERS{bus.mem_gnt}};
         end
         default: ;
      endcase
   end

   assign handshake = bus.mem_req & bus.mem_gnt;
   assign next_ptr  = (win_idx == LastIdx) ? '0 : win_idx + IdxW'(1);

   // Bank responses have fixed 1-cycle latency, so only the previous handshake can be routed.
   always_comb begin
      bus.m_r_valid = '0;
      for (int unsigned i = 0; i < NB_MASTERS; i++) begin
         bus.m_r_rdata[i] = bus.mem_r_rdata;
         if (rsp_pend_q && (rsp_id_q == RSP_ID_W'(i))) begin
            bus.m_r_valid[i] = bus.mem_r_valid;
         end
      end
   end

   assign bus.m_r_opc = '0;
   assign busy_o      = busy_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StInitZero;
         rr_ptr_q   <= '0;
         cnt_q      <= '0;
         rsp_pend_q <= 1'b0;
         rsp_id_q   <= INIT_RSP_ID;
         busy_q     <= 1'b1;
      end else begin
         rsp_pend_q <= handshake;
         if (handshake) begin
            rsp_id_q <= (state_q == StRun) ? RSP_ID_W'(win_idx) : INIT_RSP_ID;
         end
         case (state_q)
            StInitZero: begin
               if (bus.mem_gnt) begin
                  cnt_q <= cnt_q + CntW'(1);
                  if (cnt_q == CntMax) begin
                     state_q <= StRun;
                     busy_q  <= 1'b0;
                  end
               end
            end
            StRun: begin
               if (handshake) begin
                  rr_ptr_q <= next_ptr;
               end
               if (clear_i) begin
                  state_q <= StDrain;
                  busy_q  <= 1'b1;
               end
            end
            StDrain: begin
               // A pending response retires this very cycle, so DRAIN never lasts past one cycle.
               if (!rsp_pend_q || bus.mem_r_valid) begin
                  state_q <= StInitZero;
                  cnt_q   <= '0;
               end
            end
            default: begin
               state_q <= StInitZero;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l2_bank_arbiter.sv
// Randomized self-checking bench for l2_bank_arbiter against a transaction-level model.
module tb_l2_bank_arbiter;
   import l2_arb_pkg::*;

   localparam int unsigned NM   = 2;
   localparam int unsigned BW   = 16;
   localparam logic [31:0] BASE = 32'h1C00_0000;

   logic clk_i   = 1'b0;
   logic rst_ni  = 1'b1;
   logic clear_i = 1'b0;
   logic busy_o;

   l2_bank_arbiter_if #(.NB_MASTERS(NM)) bus ();

   l2_bank_arbiter #(
      .NB_MASTERS (NM),
      .BANK_WORDS (BW),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .busy_o  (busy_o),
      .bus     (bus)
   );

   always #5 clk_i = ~clk_i;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [35:0] merge_be(input logic [35:0] old_w, input logic [35:0] new_w,
                                            input logic [3:0] be);
      logic [35:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) begin
            r[8*b +: 8] = new_w[8*b +: 8];
            r[32 + b]   = new_w[32 + b];
         end
      end
      return r;
   endfunction

   // Single-port bank with fixed 1-cycle response latency.
   logic [35:0] bank [BW];
   always @(posedge clk_i) begin
      bus.mem_r_valid <= bus.mem_req && bus.mem_gnt;
      bus.mem_r_rdata <= '0;
      if (bus.mem_req && bus.mem_gnt) begin
         if (bus.mem_wen) bus.mem_r_rdata <= bank[bus.mem_add[5:2]];
         else bank[bus.mem_add[5:2]] <= merge_be(bank[bus.mem_add[5:2]], bus.mem_wdata, bus.mem_be);
      end
   end

   // Reference model state.
   logic [35:0] ref_mem [BW];
   int          ptr;
   bit          prev_hs;
   int          prev_w;
   bit          prev_rd;
   logic [35:0] prev_data;
   bit          pend [NM];

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic run_cycle();
      int          w;
      int          widx;
      logic [NM-1:0] exp_rv;
      logic [NM-1:0] exp_gnt;
      #1;
      exp_rv = '0;
      if (prev_hs) exp_rv[prev_w] = 1'b1;
      check_eq("r_valid", 64'(bus.m_r_valid), 64'(exp_rv));
      if (prev_hs && prev_rd) check_eq("r_rdata", 64'(bus.m_r_rdata[prev_w]), 64'(prev_data));
      w = -1;
      for (int k = 0; k < NM; k++) begin
         int c;
         c = (ptr + k) % NM;
         if (w < 0 && bus.m_req[c]) w = c;
      end
      check_eq("mem_req", 64'(bus.mem_req), 64'(w >= 0));
      exp_gnt = '0;
      if (w >= 0 && bus.mem_gnt) exp_gnt[w] = 1'b1;
      check_eq("m_gnt", 64'(bus.m_gnt), 64'(exp_gnt));
      prev_hs = 1'b0;
      if (w >= 0) begin
         check_eq("mem_add", 64'(bus.mem_add), 64'(bus.m_add[w]));
         check_eq("mem_wen", 64'(bus.mem_wen), 64'(bus.m_wen[w]));
         check_eq("mem_be", 64'(bus.mem_be), 64'(bus.m_be[w]));
         check_eq("mem_wdata", 64'(bus.mem_wdata), 64'(bus.m_wdata[w]));
         if (bus.mem_gnt) begin
            widx      = int'((bus.m_add[w] - BASE) >> 2);
            prev_hs   = 1'b1;
            prev_w    = w;
            prev_rd   = bus.m_wen[w];
            prev_data = ref_mem[widx];
            if (!bus.m_wen[w]) ref_mem[widx] = merge_be(ref_mem[widx], bus.m_wdata[w], bus.m_be[w]);
            ptr     = (w + 1) % NM;
            pend[w] = 1'b0;
         end
      end
      tick();
   endtask

   task automatic set_random_reqs();
      for (int m = 0; m < NM; m++) begin
         if (!pend[m] && ($urandom_range(0, 1) == 1)) begin
            pend[m]          = 1'b1;
            bus.m_add[m]     = BASE + 32'(4 * $urandom_range(0, BW - 1));
            bus.m_wen[m]     = 1'($urandom_range(0, 1));
            bus.m_be[m]      = 4'($urandom_range(1, 15));
            bus.m_wdata[m]   = {4'($urandom_range(0, 15)), 32'($urandom)};
         end
         bus.m_req[m] = pend[m];
      end
   endtask

   task automatic run_zero(input bit rand_gnt);
      int seen [BW];
      int cnt;
      int cyc;
      int n_once;
      cnt = 0;
      cyc = 0;
      for (int i = 0; i < BW; i++) seen[i] = 0;
      while (cnt < BW && cyc < 400) begin
         bus.mem_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         check_eq("zero_req", 64'(bus.mem_req), 64'(1));
         check_eq("zero_wen", 64'(bus.mem_wen), 64'(0));
         check_eq("zero_be", 64'(bus.mem_be), 64'(4'hF));
         check_eq("zero_wdata", 64'(bus.mem_wdata), 64'(0));
         check_eq("zero_busy", 64'(busy_o), 64'(1));
         check_eq("zero_gnt", 64'(bus.m_gnt), 64'(0));
         check_eq("zero_rvalid", 64'(bus.m_r_valid), 64'(0));
         check_eq("zero_add", 64'(bus.mem_add), 64'(BASE + 32'(4 * cnt)));
         if (bus.mem_gnt) begin
            seen[int'(bus.mem_add[5:2])]++;
            cnt++;
         end
         cyc++;
         tick();
      end
      check_eq("zero_done", 64'(cnt), 64'(BW));
      n_once = 0;
      for (int i = 0; i < BW; i++) if (seen[i] == 1) n_once++;
      check_eq("zero_once", 64'(n_once), 64'(BW));
      bus.mem_gnt = 1'b1;
      #1;
      check_eq("run_busy", 64'(busy_o), 64'(0));
      check_eq("run_rvalid", 64'(bus.m_r_valid), 64'(0));
      for (int i = 0; i < BW; i++) ref_mem[i] = '0;
      prev_hs = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_busy"}, 64'(busy_o), 64'(1));
      check_eq({tag, "_gnt"}, 64'(bus.m_gnt), 64'(0));
      check_eq({tag, "_rvalid"}, 64'(bus.m_r_valid), 64'(0));
      check_eq({tag, "_opc"}, 64'(bus.m_r_opc), 64'(0));
      check_eq({tag, "_mreq"}, 64'(bus.mem_req), 64'(1));
      check_eq({tag, "_madd"}, 64'(bus.mem_add), 64'(BASE));
      check_eq({tag, "_mwen"}, 64'(bus.mem_wen), 64'(0));
      check_eq({tag, "_mbe"}, 64'(bus.mem_be), 64'(4'hF));
      check_eq({tag, "_mwdata"}, 64'(bus.mem_wdata), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.m_req   = '0;
      bus.m_add   = '0;
      bus.m_wen   = '0;
      bus.m_be    = '0;
      bus.m_wdata = '0;
      bus.mem_gnt = 1'b1;
      for (int m = 0; m < NM; m++) pend[m] = 1'b0;
      ptr     = 0;
      prev_hs = 1'b0;

      #1 rst_ni = 1'b0;
      #11;
      check_reset_outputs("rst");
      rst_ni = 1'b1;
      run_zero(1'b0);

      // Both masters read every cycle: grants must alternate starting at master 0.
      for (int k = 0; k < 6; k++) begin
         bus.m_req   = 2'b11;
         bus.m_wen   = 2'b11;
         bus.m_be[0] = 4'hF;
         bus.m_be[1] = 4'hF;
         bus.m_add[0] = BASE + 32'(4 * k);
         bus.m_add[1] = BASE + 32'(4 * (k + 1));
         #1;
         check_eq("alt_gnt", 64'(bus.m_gnt), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
         run_cycle();
      end

      // Tagged write by master 1, read back by master 0.
      bus.m_req      = 2'b10;
      bus.m_wen[1]   = 1'b0;
      bus.m_add[1]   = BASE + 32'h8;
      bus.m_be[1]    = 4'hF;
      bus.m_wdata[1] = 36'hF_DEAD_BEEF;
      run_cycle();
      bus.m_req    = 2'b01;
      bus.m_wen[0] = 1'b1;
      bus.m_add[0] = BASE + 32'h8;
      run_cycle();
      bus.m_req = 2'b00;
      #1;
      check_eq("tag_rd", 64'(bus.m_r_rdata[0]), 64'(36'hF_DEAD_BEEF));
      run_cycle();

      // clear_i together with a read handshake.
      bus.m_req    = 2'b01;
      bus.m_wen[0] = 1'b1;
      bus.m_add[0] = BASE + 32'h8;
      clear_i      = 1'b1;
      run_cycle();
      clear_i   = 1'b0;
      bus.m_req = 2'b11;
      bus.m_wen = 2'b11;
      #1;
      check_eq("clr_rvalid", 64'(bus.m_r_valid), 64'(2'b01));
      check_eq("clr_rdata", 64'(bus.m_r_rdata[0]), 64'(36'hF_DEAD_BEEF));
      check_eq("drain_req", 64'(bus.mem_req), 64'(0));
      check_eq("drain_gnt", 64'(bus.m_gnt), 64'(0));
      check_eq("drain_busy", 64'(busy_o), 64'(1));
      tick();
      prev_hs = 1'b0;
      run_zero(1'b1);
      bus.m_req    = 2'b01;
      bus.m_add[0] = BASE + 32'h8;
      run_cycle();
      bus.m_req = 2'b00;
      #1;
      check_eq("clr_zero", 64'(bus.m_r_rdata[0]), 64'(0));
      run_cycle();

      // Random traffic with random bank back-pressure.
      for (int m = 0; m < NM; m++) pend[m] = 1'b0;
      for (int n = 0; n < 300; n++) begin
         set_random_reqs();
         bus.mem_gnt = ($urandom_range(0, 3) != 0);
         run_cycle();
      end

      // Asynchronous reset in the middle of RUN with a response in flight.
      bus.m_req   = 2'b11;
      bus.m_wen   = 2'b11;
      bus.mem_gnt = 1'b1;
      tick();
      #2 rst_ni = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      tick();
      tick();
      rst_ni  = 1'b1;
      ptr     = 0;
      prev_hs = 1'b0;
      run_zero(1'b0);
      for (int m = 0; m < NM; m++) pend[m] = 1'b1;
      for (int n = 0; n < 100; n++) begin
         set_random_reqs();
         bus.mem_gnt = ($urandom_range(0, 3) != 0);
         run_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/l2_bank_arbiter.md
# l2_bank_arbiter

Shares one single-port L2 SRAM bank (36-bit TCDM data: 32 data bits plus 4 DIFT tag bits) between NB_MASTERS requesters using round-robin arbitration. It also contains a zeroing sequencer that clears every word, data and tags, after reset and on software request. It sits between the SoC interconnect ports and a private or interleaved L2 bank, and routes the bank's fixed 1-cycle-latency responses back to the master that issued the request.

## Interface
- NB_MASTERS, 2: number of requesters (2..8).
- BANK_WORDS, 8192: bank depth in 32-bit words (power of two).
- BASE_ADDR, 32'h1C000000: byte address of word 0; driven on mem_add_o during zeroing.
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  asynchronous, active-low reset.
- clear_i  in  1  one-cycle pulse that requests a re-zero of the bank.
- busy_o  out  1  high while not in RUN.
- m_req_i  in  NB_MASTERS  request per master.
- m_add_i  in  NB_MASTERS×32  byte address per master.
- m_wen_i  in  NB_MASTERS  per master; 1 = read, 0 = write.
- m_be_i  in  NB_MASTERS×4  byte enables per master.
- m_wdata_i  in  NB_MASTERS×36  write data per master; bits [35:32] are tags.
- m_gnt_o  out  NB_MASTERS  grant per master.
- m_r_valid_o  out  NB_MASTERS  response valid per master.
- m_r_rdata_o  out  NB_MASTERS×36  read data per master.
- m_r_opc_o  out  NB_MASTERS  response error flag; constant 0.
- mem_req_o, mem_add_o[31:0], mem_wen_o, mem_be_o[3:0], mem_wdata_o[35:0]  out  to the bank.
- mem_gnt_i, mem_r_valid_i, mem_r_rdata_i[35:0]  in  from the bank.

## Operation
- States:
  - INIT_ZERO: entered on reset.
  - RUN.
  - DRAIN.
- INIT_ZERO:
  - Drive mem_req_o=1, mem_wen_o=0, mem_be_o=4'hF, mem_wdata_o=0, mem_add_o=BASE_ADDR+4·cnt.
  - cnt is a $clog2(BANK_WORDS)-bit counter that increments only on mem_gnt_i.
  - When cnt=BANK_WORDS-1 and mem_gnt_i=1, go to RUN; cnt wraps to 0.
  - All m_gnt_o are 0 in this state.
- RUN:
  - Winner = first requesting master at or after rr_ptr, searching in increasing index with wrap.
  - mem_* driven from the winner.
  - m_gnt_o[winner] = mem_gnt_i; all other m_gnt_o are 0.
  - On each handshake (mem_req_o & mem_gnt_i): rr_ptr <= (winner+1) mod NB_MASTERS.
  - With no request: mem_req_o=0 and rr_ptr holds.
- clear_i in RUN: go to DRAIN. clear_i in INIT_ZERO or DRAIN is ignored (no restart, no queueing).
- DRAIN:
  - mem_req_o=0 and all m_gnt_o=0.
  - Go to INIT_ZERO once no response is outstanding (rsp_pend_q=0); this takes at most 1 cycle.
- Response routing:
  - On a handshake: rsp_pend_q <= 1; rsp_id_q <= winner, or an INIT marker during zeroing.
  - m_r_valid_o[rsp_id_q] = mem_r_valid_i, only for non-INIT responses.
  - m_r_rdata_o of every master = mem_r_rdata_i.
  - Responses to zeroing writes are dropped.
- Reset mid-operation: all state clears; a pending response is lost; zeroing restarts at cnt=0.

## Timing
- Outputs after reset:
  - busy_o=1, all m_gnt_o=0, all m_r_valid_o=0, m_r_opc_o=0.
  - rr_ptr=0, cnt=0, rsp_pend_q=0.
  - mem_req_o=1 with a zero write to BASE_ADDR.
- Grant is combinational in the same cycle as the request.
- The read response arrives exactly 1 cycle after the handshake, combinationally routed from mem_r_valid_i.
- Back-to-back grants are allowed every cycle.
- Zeroing takes BANK_WORDS cycles with mem_gnt_i held at 1.
- busy_o deasserts in the first RUN cycle.
- A master must hold req/add/wen/be/wdata stable until it sees gnt.

## Structure
- Shared package l2_arb_pkg holds:
  - state enum (INIT_ZERO, RUN, DRAIN);
  - TCDM_DW=36 and TAG_W=4 constants;
  - the INIT marker id.
- One sub-module, rr_arb_tree_lite: a parameterized round-robin priority picker (req vector and pointer in; one-hot grant and index out).
- Top level holds the FSM, the counter and the response register.

## Test plan
- Reset, mem_gnt_i tied to 1, BANK_WORDS=16:
  - 16 zero writes to BASE_ADDR..BASE_ADDR+0x3C;
  - then busy_o=0;
  - no m_r_valid_o pulses during zeroing.
- RUN, both masters request every cycle:
  - grants alternate 0,1,0,1;
  - each m_r_valid_o pulses exactly 1 cycle after that master's own gnt.
- Master 1 writes 36'hF_DEADBEEF to BASE_ADDR+8; master 0 then reads BASE_ADDR+8:
  - master 0 gets rdata 36'hF_DEADBEEF, tags intact.
- clear_i during a read handshake:
  - the read response is still delivered;
  - DRAIN for 1 cycle, then zeroing restarts at cnt=0;
  - a subsequent read of BASE_ADDR+8 returns 0.
- mem_gnt_i toggled randomly during zeroing:
  - cnt advances only on grant;
  - all BANK_WORDS addresses are written exactly once.
- rst_ni asserted mid-RUN:
  - outputs return to reset values asynchronously;
  - zeroing restarts after release.
